int0_mul_wb_stage: RTL and testbench
====================================

Name: int0_mul_wb_stage

Overview:
- Output stage directly downstream of the Int0 multiplier. Registers the multiplier's result, condition codes and tag, plus the destination register id, and presents them to the Int0 writeback arbiter over a valid/ready handshake.
- A 2-entry skid buffer keeps multiplier issue at full throughput while the arbiter back-pressures.
- Keeps a sticky overflow flag and a saturating overflow event counter for the status unit.

Parameters:
- DST_W, 5, width of destination register id.
- CNT_W, 16, width of overflow event counter.

Ports:
- clk_i_mwb  in  1  clock.
- rst_i_mwb  in  1  reset; synchronous, active-high.
- vld_i_mwb  in  1  multiplier result valid (issue slot occupied).
- rdy_o_mwb  out  1  stage can accept this cycle.
- rslt_i_mwb  in  32  signed multiplier result.
- cc_i_mwb  in  2  {overflow, zero} from multiplier.
- tag_i_mwb  in  12  tag result from multiplier.
- tagop_i_mwb  in  1  operation was tag-mode (multiplier tag select).
- dst_i_mwb  in  DST_W  destination register id.
- flush_i_mwb  in  1  pipeline flush; discard all held entries.
- clr_i_mwb  in  1  clear sticky flag and counter.
- vld_o_mwb  out  1  head entry valid.
- rdy_i_mwb  in  1  writeback arbiter accepts head.
- rslt_o_mwb  out  32  head result.
- cc_o_mwb  out  2  head condition codes.
- tag_o_mwb  out  12  head tag.
- tagop_o_mwb  out  1  head tag-mode flag.
- dst_o_mwb  out  DST_W  head destination id.
- ovf_sticky_o_mwb  out  1  set by any accepted entry with cc[1]=1.
- ovf_cnt_o_mwb  out  CNT_W  number of accepted overflow entries, saturating.

Behaviour:
- Reset: state EMPTY; vld_o=0; rdy_o=1; all data outputs 0; ovf_sticky_o=0; ovf_cnt_o=0. Reset mid-operation discards all entries with no output handshake.
- Storage: head register, which drives the outputs directly, and skid register.
- push = vld_i & rdy_o. pop = vld_o & rdy_i.
- rdy_o is a registered output: 1 in EMPTY and ONE, 0 in TWO. It never depends combinationally on rdy_i.
- States and transitions:
  - EMPTY: push -> load head, go to ONE.
  - ONE, push only: load skid, go to TWO.
  - ONE, pop only: go to EMPTY.
  - ONE, push and pop: load head with the new data, stay in ONE.
  - ONE, neither: hold.
  - TWO: push is impossible because rdy_o=0. Pop -> head takes skid contents, go to ONE. No pop -> hold.
- Latency: input accepted in cycle N appears on the outputs with vld_o=1 in cycle N+1.
- Ordering: strict FIFO. An entry never changes while it is valid and not popped.
- Throughput: one accept per cycle sustained while rdy_i=1.
- Flush: go to EMPTY next cycle with vld_o=0. A same-cycle push is dropped and a same-cycle pop is honoured. The sticky flag and counter still observe that push, because the multiplier flagged overflow architecturally.
- Stored data is never modified; widths pass through unchanged.
- Overflow accounting, on push with cc_i[1]=1 (tag-mode entries included):
  - Sticky flag sets.
  - Counter increments and saturates at 2^CNT_W-1; it never wraps.
- Overflow accounting with clr_i asserted:
  - The clear takes effect first; a same-cycle overflow push then leaves sticky=1 and count=1.
  - clr_i with no overflow push gives 0/0.
- Data outputs while vld_o=0 hold their last value; the bench must not check them.

Decomposition:
- Shared Int0 package holds:
  - Width constants: RSLT_W=32, CC_W=2, TAG_W=12, DST_W.
  - CC bit indices: CC_ZERO=0, CC_OVF=1.
  - State encoding: EMPTY, ONE, TWO.
  - Packed entry struct: rslt, cc, tag, tagop, dst.
- One natural sub-module: int0_skid_buf2. It is a generic 2-entry skid FIFO over the packed entry and holds the state machine and the head/skid registers. The top level adds the overflow accounting.

Test Plan:
- Single pass: push rslt=0x0000_1234, cc=00, dst=3 with rdy_i=1 -> next cycle vld_o=1, rslt_o=0x0000_1234, dst_o=3; one cycle later vld_o=0.
- Back-pressure: rdy_i=0, push A=1, B=2 -> rdy_o=0 after B and vld_o holds A; set rdy_i=1 -> A then B on consecutive cycles, rdy_o=1 the cycle after A pops.
- Streaming: 8 pushes on consecutive cycles, values 10..17, with rdy_i=1 -> outputs 10..17 on consecutive cycles, rdy_o never 0.
- Overflow: push cc=10 three times with rslt=0x7FFF_FFFF -> sticky=1, ovf_cnt=3; clr_i with a same-cycle overflow push -> ovf_cnt=1, sticky=1.
- Saturation: with CNT_W=2, five overflow pushes -> ovf_cnt=3 and it stays 3.
- Flush/reset: state TWO, flush_i=1 with rdy_i=0 -> next cycle vld_o=0, rdy_o=1; repeat in state TWO with rst_i=1 -> all outputs 0, counter 0.

Source files
------------

// File: rtl/int0_mul_wb_stage_pkg.sv
// Shared Int0 definitions: payload widths, condition-code bit positions,
// skid FSM state encoding and the default multiplier writeback entry.
package int0_mul_wb_stage_pkg;

    localparam int unsigned RSLT_W = 32;
    localparam int unsigned CC_W   = 2;
    localparam int unsigned TAG_W  = 12;
    localparam int unsigned DST_W  = 5;

    localparam int unsigned CC_ZERO = 0;
    localparam int unsigned CC_OVF  = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [RSLT_W-1:0] rslt;
        logic [CC_W-1:0]   cc;
        logic [TAG_W-1:0]  tag;
        logic              tagop;
        logic [DST_W-1:0]  dst;
    } entry_t;

endpackage

// File: rtl/int0_skid_buf2.sv
// Generic 2-entry skid FIFO: head register feeds the consumer directly, skid
// register absorbs the one in-flight entry when the consumer stalls.
module int0_skid_buf2
    import int0_mul_wb_stage_pkg::*;
#(
    parameter type item_t = int0_mul_wb_stage_pkg::entry_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  in_vld,
    output logic  in_rdy,
    input  item_t in_data,
    output logic  out_vld,
    input  logic  out_rdy,
    output item_t out_data
);

    state_t state;
    item_t  skid;
    logic   push;
    logic   pop;

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    // in_rdy is registered from state so it never sees out_rdy combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_vld  <= 1'b0;
            in_rdy   <= 1'b1;
            out_data <= '0;
            skid     <= '0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        out_data <= in_data;
                        out_vld  <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            skid   <= in_data;
                            in_rdy <= 1'b0;
                            state  <= ST_TWO;
                        end
                        2'b01: begin
                            out_vld <= 1'b0;
                            state   <= ST_EMPTY;
                        end
                        2'b11: out_data <= in_data;
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    if (pop) begin
                        out_data <= skid;
                        in_rdy   <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    out_vld <= 1'b0;
                    in_rdy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/int0_mul_wb_stage.sv
// Int0 multiplier output stage: skid-buffered handoff to the writeback arbiter
// plus sticky overflow flag and saturating overflow event counter.
module int0_mul_wb_stage
    import int0_mul_wb_stage_pkg::RSLT_W, int0_mul_wb_stage_pkg::CC_W,
           int0_mul_wb_stage_pkg::TAG_W, int0_mul_wb_stage_pkg::CC_OVF;
#(
    parameter int unsigned DST_W = int0_mul_wb_stage_pkg::DST_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_i_mwb,
    input  logic              rst_i_mwb,
    input  logic              vld_i_mwb,
    output logic              rdy_o_mwb,
    input  logic [RSLT_W-1:0] rslt_i_mwb,
    input  logic [CC_W-1:0]   cc_i_mwb,
    input  logic [TAG_W-1:0]  tag_i_mwb,
    input  logic              tagop_i_mwb,
    input  logic [DST_W-1:0]  dst_i_mwb,
    input  logic              flush_i_mwb,
    input  logic              clr_i_mwb,
    output logic              vld_o_mwb,
    input  logic              rdy_i_mwb,
    output logic [RSLT_W-1:0] rslt_o_mwb,
    output logic [CC_W-1:0]   cc_o_mwb,
    output logic [TAG_W-1:0]  tag_o_mwb,
    output logic              tagop_o_mwb,
    output logic [DST_W-1:0]  dst_o_mwb,
    output logic              ovf_sticky_o_mwb,
    output logic [CNT_W-1:0]  ovf_cnt_o_mwb
);

    // Same layout as the package entry, with the destination width taken from DST_W
    typedef struct packed {
        logic [RSLT_W-1:0] rslt;
        logic [CC_W-1:0]   cc;
        logic [TAG_W-1:0]  tag;
        logic              tagop;
        logic [DST_W-1:0]  dst;
    } stage_entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_entry_t in_entry;
    stage_entry_t head;
    logic         ovf_push;

    assign in_entry = '{rslt:  rslt_i_mwb,
                        cc:    cc_i_mwb,
                        tag:   tag_i_mwb,
                        tagop: tagop_i_mwb,
                        dst:   dst_i_mwb};

    int0_skid_buf2 #(
        .item_t (stage_entry_t)
    ) u_skid (
        .clk      (clk_i_mwb),
        .rst      (rst_i_mwb),
        .flush    (flush_i_mwb),
        .in_vld   (vld_i_mwb),
        .in_rdy   (rdy_o_mwb),
        .in_data  (in_entry),
        .out_vld  (vld_o_mwb),
        .out_rdy  (rdy_i_mwb),
        .out_data (head)
    );

    assign rslt_o_mwb  = head.rslt;
    assign cc_o_mwb    = head.cc;
    assign tag_o_mwb   = head.tag;
    assign tagop_o_mwb = head.tagop;
    assign dst_o_mwb   = head.dst;

    // Overflow is architectural at accept time, so a push dropped by flush still counts
    assign ovf_push = vld_i_mwb & rdy_o_mwb & cc_i_mwb[CC_OVF];

    always_ff @(posedge clk_i_mwb) begin
        if (rst_i_mwb) begin
            ovf_sticky_o_mwb <= 1'b0;
            ovf_cnt_o_mwb    <= '0;
        end else if (clr_i_mwb) begin
            ovf_sticky_o_mwb <= ovf_push;
            ovf_cnt_o_mwb    <= ovf_push ? CNT_W'(1) : '0;
        end else if (ovf_push) begin
            ovf_sticky_o_mwb <= 1'b1;
            if (ovf_cnt_o_mwb != CNT_MAX) begin
                ovf_cnt_o_mwb <= ovf_cnt_o_mwb + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_int0_mul_wb_stage.sv
// Directed bench for int0_mul_wb_stage; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_int0_mul_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_i;
    logic        rdy_o;
    logic [31:0] rslt_i;
    logic [1:0]  cc_i;
    logic [11:0] tag_i;
    logic        tagop_i;
    logic [4:0]  dst_i;
    logic        flush;
    logic        clr;
    logic        vld_o;
    logic        rdy_i;
    logic [31:0] rslt_o;
    logic [1:0]  cc_o;
    logic [11:0] tag_o;
    logic        tagop_o;
    logic [4:0]  dst_o;
    logic        sticky;
    logic [15:0] cnt;

    logic        rdy_o2;
    logic        vld_o2;
    logic [31:0] rslt_o2;
    logic [1:0]  cc_o2;
    logic [11:0] tag_o2;
    logic        tagop_o2;
    logic [4:0]  dst_o2;
    logic        sticky2;
    logic [1:0]  cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int0_mul_wb_stage dut (
        .clk_i_mwb (clk), .rst_i_mwb (rst), .vld_i_mwb (vld_i), .rdy_o_mwb (rdy_o),
        .rslt_i_mwb (rslt_i), .cc_i_mwb (cc_i), .tag_i_mwb (tag_i), .tagop_i_mwb (tagop_i),
        .dst_i_mwb (dst_i), .flush_i_mwb (flush), .clr_i_mwb (clr), .vld_o_mwb (vld_o),
        .rdy_i_mwb (rdy_i), .rslt_o_mwb (rslt_o), .cc_o_mwb (cc_o), .tag_o_mwb (tag_o),
        .tagop_o_mwb (tagop_o), .dst_o_mwb (dst_o), .ovf_sticky_o_mwb (sticky),
        .ovf_cnt_o_mwb (cnt)
    );

    int0_mul_wb_stage #(.CNT_W(2)) dut2 (
        .clk_i_mwb (clk), .rst_i_mwb (rst), .vld_i_mwb (vld_i), .rdy_o_mwb (rdy_o2),
        .rslt_i_mwb (rslt_i), .cc_i_mwb (cc_i), .tag_i_mwb (tag_i), .tagop_i_mwb (tagop_i),
        .dst_i_mwb (dst_i), .flush_i_mwb (flush), .clr_i_mwb (clr), .vld_o_mwb (vld_o2),
        .rdy_i_mwb (rdy_i), .rslt_o_mwb (rslt_o2), .cc_o_mwb (cc_o2), .tag_o_mwb (tag_o2),
        .tagop_o_mwb (tagop_o2), .dst_o_mwb (dst_o2), .ovf_sticky_o_mwb (sticky2),
        .ovf_cnt_o_mwb (cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [1:0] c,
                         input logic [4:0] d);
        vld_i  = v;
        rslt_i = r;
        cc_i   = c;
        dst_i  = d;
    endtask

    initial begin
        rst = 1'b1; vld_i = 1'b0; rslt_i = '0; cc_i = '0; tag_i = '0; tagop_i = 1'b0;
        dst_i = '0; flush = 1'b0; clr = 1'b0; rdy_i = 1'b0;
        tick();
        tick();
        check("rst_vld", 64'(vld_o), 64'd0);
        check("rst_rdy", 64'(rdy_o), 64'd1);
        check("rst_rslt", 64'(rslt_o), 64'd0);
        check("rst_cc", 64'(cc_o), 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
        check("rst_dst", 64'(dst_o), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        rst = 1'b0;

        // single pass
        rdy_i = 1'b1;
        drive(1'b1, 32'h0000_1234, 2'b00, 5'd3);
        tick();
        check("single_vld", 64'(vld_o), 64'd1);
        check("single_rslt", 64'(rslt_o), 64'h1234);
        check("single_dst", 64'(dst_o), 64'd3);
        vld_i = 1'b0;
        tick();
        check("single_drain", 64'(vld_o), 64'd0);

        // back-pressure into TWO, then drain in order
        rdy_i = 1'b0;
        drive(1'b1, 32'd1, 2'b00, 5'd1);
        tick();
        check("bp_a_vld", 64'(vld_o), 64'd1);
        check("bp_a_rdy", 64'(rdy_o), 64'd1);
        drive(1'b1, 32'd2, 2'b00, 5'd2);
        tick();
        check("bp_two_rdy", 64'(rdy_o), 64'd0);
        check("bp_hold_a", 64'(rslt_o), 64'd1);
        vld_i = 1'b0;
        tick();
        check("bp_hold_a2", 64'(rslt_o), 64'd1);
        rdy_i = 1'b1;
        tick();
        check("bp_b_vld", 64'(vld_o), 64'd1);
        check("bp_b_rslt", 64'(rslt_o), 64'd2);
        check("bp_b_dst", 64'(dst_o), 64'd2);
        check("bp_rdy_back", 64'(rdy_o), 64'd1);
        tick();
        check("bp_empty", 64'(vld_o), 64'd0);

        // streaming at full rate
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(10 + i), 2'b00, 5'(i));
            tick();
            check("stream_vld", 64'(vld_o), 64'd1);
            check("stream_rslt", 64'(rslt_o), 64'(10 + i));
            check("stream_rdy", 64'(rdy_o), 64'd1);
        end
        vld_i = 1'b0;
        tick();
        check("stream_drain", 64'(vld_o), 64'd0);

        // overflow accounting, zero-flag entry must not count
        drive(1'b1, 32'h0, 2'b01, 5'd4);
        tick();
        check("zero_cc", 64'(cc_o), 64'b01);
        check("zero_cnt", 64'(cnt), 64'd0);
        check("zero_sticky", 64'(sticky), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'h7FFF_FFFF, 2'b10, 5'd5);
            tick();
            check("ovf_cnt", 64'(cnt), 64'(i));
        end
        check("ovf_sticky", 64'(sticky), 64'd1);
        check("ovf_cc_out", 64'(cc_o), 64'b10);
        check("ovf_rslt_out", 64'(rslt_o), 64'h7FFF_FFFF);
        clr = 1'b1;
        tick();
        check("clr_push_cnt", 64'(cnt), 64'd1);
        check("clr_push_sticky", 64'(sticky), 64'd1);
        vld_i = 1'b0;
        tick();
        check("clr_cnt", 64'(cnt), 64'd0);
        check("clr_sticky", 64'(sticky), 64'd0);
        check("clr_cnt2", 64'(cnt2), 64'd0);
        clr = 1'b0;

        // saturation on the 2-bit instance, tag-mode entries included
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i), 2'b10, 5'd7);
            tag_i   = 12'hABC;
            tagop_i = 1'b1;
            tick();
            check("sat_cnt2", 64'(cnt2), 64'((i > 3) ? 3 : i));
            check("sat_cnt", 64'(cnt), 64'(i));
        end
        check("tag_out", 64'(tag_o), 64'hABC);
        check("tagop_out", 64'(tagop_o), 64'd1);
        check("sat_sticky2", 64'(sticky2), 64'd1);
        vld_i = 1'b0; tagop_i = 1'b0; tag_i = '0;
        tick();
        check("sat_hold2", 64'(cnt2), 64'd3);

        // flush in TWO with arbiter stalled
        rdy_i = 1'b0;
        drive(1'b1, 32'hA, 2'b00, 5'd1);
        tick();
        drive(1'b1, 32'hB, 2'b00, 5'd2);
        tick();
        check("fl_two_rdy", 64'(rdy_o), 64'd0);
        vld_i = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_vld", 64'(vld_o), 64'd0);
        check("fl_rdy", 64'(rdy_o), 64'd1);

        // flush drops a same-cycle push but still counts its overflow
        drive(1'b1, 32'hC, 2'b10, 5'd3);
        tick();
        check("fl1_vld", 64'(vld_o), 64'd1);
        drive(1'b1, 32'hD, 2'b10, 5'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vld_i = 1'b0;
        check("flpush_vld", 64'(vld_o), 64'd0);
        check("flpush_cnt", 64'(cnt), 64'd7);
        check("flpush_cnt2", 64'(cnt2), 64'd3);
        tick();
        check("flpush_dropped", 64'(vld_o), 64'd0);

        // reset in TWO
        drive(1'b1, 32'h55, 2'b00, 5'd9);
        tick();
        drive(1'b1, 32'h66, 2'b00, 5'd10);
        tick();
        check("rs_two_rdy", 64'(rdy_o), 64'd0);
        vld_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_vld", 64'(vld_o), 64'd0);
        check("rs_rdy", 64'(rdy_o), 64'd1);
        check("rs_rslt", 64'(rslt_o), 64'd0);
        check("rs_dst", 64'(dst_o), 64'd0);
        check("rs_cnt", 64'(cnt), 64'd0);
        check("rs_sticky", 64'(sticky), 64'd0);
        check("rs_cnt2", 64'(cnt2), 64'd0);
        rdy_i = 1'b1;
        tick();
        check("rs_no_hs", 64'(vld_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
